// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: command FIFO + sequencer in front of a registered 8-bit ALU.
// Commands are queued, issued one at a time to the ALU, and their results are
// returned in order with the caller's tag.
// Optional build macro: ALU_DIV0_FLAG_EN (flags divide-by-zero on op 3).
module alu_cmd_issuer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LAT   = 1,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [2:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [2:0]       alu_op,
    input  logic [7:0]       alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(LAT + 1);
    localparam int unsigned EW = 19 + TAG_W;

    typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_result_q, rsp_result_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic             rsp_err_q, rsp_err_d;

    logic             full, empty, push, pop;
    logic [7:0]       head_a, head_b;
    logic [2:0]       head_op;
    logic [TAG_W-1:0] head_tag;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = cmd_valid && !full;
    assign pop   = (state_q == StIdle) && !empty;
    assign {head_a, head_b, head_op, head_tag} = mem_q[rd_ptr_q[AW-1:0]];

    // FIFO storage; pointers guard validity so the array needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {cmd_a, cmd_b, cmd_op, cmd_tag};
        end
    end

    // Next-state for FIFO pointers, sequencer and response registers.
    always_comb begin
        wr_ptr_d     = wr_ptr_q + (AW + 1)'(push);
        rd_ptr_d     = rd_ptr_q + (AW + 1)'(pop);
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        tag_d        = tag_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_err_d    = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    alu_a_d  = head_a;
                    alu_b_d  = head_b;
                    alu_op_d = head_op;
                    tag_d    = head_tag;
                    cnt_d    = CW'(LAT);
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = alu_out;
                    rsp_tag_d    = tag_q;
                    rsp_err_d    = 1'b0;
`ifdef ALU_DIV0_FLAG_EN
                    // alu_* are held through WAIT, so they still describe this op.
                    if (alu_op_q == 3'd3 && alu_b_q == 8'h00) begin
                        rsp_result_d = 8'hFF;
                        rsp_err_d    = 1'b1;
                    end
`endif
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHold: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            state_q      <= StIdle;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            tag_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_tag_q    <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            tag_q        <= tag_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign cmd_ready  = !full;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed cases plus a randomized run
// scored against an in-order queue of expected responses.
// Honours ALU_DIV0_FLAG_EN when computing expected divide-by-zero responses.
module tb_alu_cmd_issuer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a, cmd_b;
    logic [2:0] cmd_op;
    logic [3:0] cmd_tag;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [3:0] rsp_tag;
    logic       rsp_err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] res;
        logic [3:0] tag;
        logic       err;
    } exp_t;

    exp_t sb[$];

    alu_cmd_issuer #(.DEPTH(4), .LAT(1), .TAG_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .cmd_tag    (cmd_tag),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_tag    (rsp_tag),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Behaviour of the external ALU as seen by the issuer.
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return (b == 8'h00) ? 8'h00 : a / b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            3'd6:    return {a[6:0], a[7]};
            default: return {a[0], a[7:1]};
        endcase
    endfunction

    // Registered ALU, one edge of latency.
    always @(posedge clk) alu_out <= alu_fn(alu_a, alu_b, alu_op);

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic [2:0] op, input logic [3:0] tag);
        exp_t e;
        e.res = alu_fn(a, b, op);
        e.tag = tag;
        e.err = 1'b0;
`ifdef ALU_DIV0_FLAG_EN
        if (op == 3'd3 && b == 8'h00) begin
            e.res = 8'hFF;
            e.err = 1'b1;
        end
`endif
        return e;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Compare the presented response with the oldest outstanding expectation.
    task automatic chk_rsp(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            check({nm, "_spurious"}, 32'(rsp_valid), 32'd0);
        end else begin
            e = sb.pop_front();
            check({nm, "_res"}, 32'(rsp_result), 32'(e.res));
            check({nm, "_tag"}, 32'(rsp_tag), 32'(e.tag));
            check({nm, "_err"}, 32'(rsp_err), 32'(e.err));
        end
    endtask

    // Drain outstanding responses with rsp_ready held high.
    task automatic drain(input string nm);
        int n = 0;
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        while (sb.size() > 0 && n < 300) begin
            if (rsp_valid) chk_rsp(nm);
            cyc();
            n++;
        end
        check({nm, "_drained"}, 32'(sb.size()), 32'd0);
        repeat (2) cyc();
        check({nm, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Single command from idle: check acceptance, latency and response.
    task automatic do_one(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                          input logic [3:0] tag, input string nm);
        exp_t e;
        int   n = 0;
        e = model(a, b, op, tag);
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
        check({nm, "_ready"}, 32'(cmd_ready), 32'd1);
        cyc();
        cmd_valid = 1'b0;
        while (!rsp_valid && n < 20) begin
            cyc();
            n++;
        end
        check({nm, "_lat"}, 32'(n), 32'd3);
        check({nm, "_res"}, 32'(rsp_result), 32'(e.res));
        check({nm, "_tag"}, 32'(rsp_tag), 32'(e.tag));
        check({nm, "_err"}, 32'(rsp_err), 32'(e.err));
        cyc();
        check({nm, "_done"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int         acc;
        int         cnt;
        logic [7:0] hr;
        logic [3:0] ht;
        logic       he;
        logic       held;

        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;

        // T1: reset values
        cyc(); cyc();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
        check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        rst_n = 1'b1;
        cyc();

        // T2/T3/T6: single operations
        do_one(8'h05, 8'h03, 3'd0, 4'd1, "t2_add");
        do_one(8'hFF, 8'h01, 3'd0, 4'd2, "t3_wrap");
        do_one(8'h81, 8'h00, 3'd6, 4'd3, "t3_rol");
        do_one(8'h10, 8'h00, 3'd3, 4'd4, "t6_div0");
        do_one(8'h64, 8'h07, 3'd3, 4'd5, "t6_div");

        // T4: back-pressure fills the pipeline and FIFO
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_op = 3'($urandom);
            cmd_tag = 4'(acc);
            if (cmd_ready) begin
                sb.push_back(model(cmd_a, cmd_b, cmd_op, cmd_tag));
                acc++;
            end
            cyc();
        end
        cmd_valid = 1'b0;
        check("t4_accepts", 32'(acc), 32'd5);
        check("t4_full", 32'(cmd_ready), 32'd0);
        check("t4_valid", 32'(rsp_valid), 32'd1);
        hr = rsp_result; ht = rsp_tag; he = rsp_err;
        cnt = 0;
        repeat (10) begin
            cyc();
            if ({rsp_valid, rsp_result, rsp_tag, rsp_err} !== {1'b1, hr, ht, he}) cnt++;
        end
        check("t4_stable", 32'(cnt), 32'd0);
        drain("t4_order");

        // T5: reset while an op is in WAIT with two queued behind it
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_a = 8'(i + 1); cmd_b = 8'h01; cmd_op = 3'd0; cmd_tag = 4'(i);
            cyc();
        end
        cmd_valid = 1'b0;
        check("t5_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin
            if (rsp_valid) cnt++;
            cyc();
        end
        check("t5_no_rsp", 32'(cnt), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ready", 32'(cmd_ready), 32'd1);

        // Randomized traffic with random back-pressure
        held = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cmd_valid = ($urandom % 2) == 0;
            cmd_a     = 8'($urandom);
            cmd_b     = (($urandom % 8) == 0) ? 8'h00 : 8'($urandom);
            cmd_op    = 3'($urandom);
            cmd_tag   = 4'($urandom);
            rsp_ready = ($urandom % 4) != 0;
            if (held) begin
                check("rnd_hold", 32'({rsp_valid, rsp_result, rsp_tag, rsp_err}),
                      32'({1'b1, hr, ht, he}));
            end
            if (rsp_valid && rsp_ready) chk_rsp("rnd");
            held = rsp_valid && !rsp_ready;
            hr = rsp_result; ht = rsp_tag; he = rsp_err;
            if (cmd_valid && cmd_ready) sb.push_back(model(cmd_a, cmd_b, cmd_op, cmd_tag));
            cyc();
        end
        drain("rnd_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
